// File: rtl/conv_window_ctrl.sv
// Sequencer for one convolver lane's shift register chain: raster pixel intake, position tracking
// and KSIZE x KSIZE window flags. Define CONV_WINDOW_STRIDE2_EN to flag only stride-2 windows.
`ifndef WID_FIFO
`define WID_FIFO 8
`endif

module conv_window_ctrl #(
  parameter int unsigned DIM_W = 10,
  parameter int unsigned KSIZE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIM_W-1:0]     img_width,
  input  logic [DIM_W-1:0]     img_height,
  input  logic                 pix_valid,
  input  logic [`WID_FIFO-1:0] pix_data,
  output logic                 pix_ready,
  input  logic                 out_stall,
  output logic                 shifting,
  output logic [`WID_FIFO-1:0] sr_data,
  output logic                 win_valid,
  output logic [DIM_W-1:0]     win_row,
  output logic [DIM_W-1:0]     win_col,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [DIM_W-1:0] KSize = DIM_W'(KSIZE);
  localparam logic [DIM_W-1:0] KEdge = DIM_W'(KSIZE - 1);
  localparam logic [DIM_W-1:0] One   = DIM_W'(1);

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic             win_valid_q, win_valid_d;
  logic [DIM_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
  logic             cfg_err_q, cfg_err_d;

  logic             fire, last_col, last_row, win_hit;
  logic [DIM_W-1:0] top_row, left_col;

  always_comb begin
    pix_ready = (state_q == StRun) && !out_stall;
    fire      = pix_valid && pix_ready;
    shifting  = fire;
    sr_data   = pix_data;
    busy      = (state_q == StRun) || (state_q == StFlush);
    done      = (state_q == StDone);
    win_valid = win_valid_q;
    win_row   = win_row_q;
    win_col   = win_col_q;
    cfg_err   = cfg_err_q;

    last_col  = (col_q == width_q - One);
    last_row  = (row_q == height_q - One);
    top_row   = row_q - KEdge;
    left_col  = col_q - KEdge;
    // Abort in the same cycle drops the window this fire would otherwise produce.
`ifdef CONV_WINDOW_STRIDE2_EN
    win_hit   = fire && !abort && (row_q >= KEdge) && (col_q >= KEdge) &&
                !top_row[0] && !left_col[0];
`else
    win_hit   = fire && !abort && (row_q >= KEdge) && (col_q >= KEdge);
`endif
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    width_d     = width_q;
    height_d    = height_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    cfg_err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if ((img_width >= KSize) && (img_height >= KSize)) begin
            width_d  = img_width;
            height_d = img_height;
            col_d    = '0;
            row_d    = '0;
            state_d  = StRun;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
        end else if (fire) begin
          if (win_hit) begin
            win_valid_d = 1'b1;
            win_row_d   = top_row;
            win_col_d   = left_col;
          end
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = StFlush;
            end else begin
              row_d = row_q + One;
            end
          end else begin
            col_d = col_q + One;
          end
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      height_q    <= height_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequences the convolver's per-row two-stage shift register chain. It accepts a raster-order pixel stream with a valid/ready handshake, drives the common `shifting` enable, and tracks the row and column position.
- It flags each cycle on which the shift chain plus line buffers hold a complete KSIZE x KSIZE window, and reports that window's top-left coordinate.
- One instance sits per convolver lane, between the input FIFO read port and the shift register bank.

Parameters:
- DIM_W, 10, width of image dimension and position counters.
- KSIZE, 3, kernel edge length; window is valid once KSIZE-1 prior rows and columns have been shifted in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- start  in  1  begin frame; sampled only in IDLE.
- abort  in  1  terminate frame; sampled in RUN.
- img_width  in  DIM_W  pixels per row; latched on accepted start.
- img_height  in  DIM_W  rows per frame; latched on accepted start.
- pix_valid  in  1  upstream pixel available.
- pix_data  in  `WID_FIFO  upstream pixel.
- pix_ready  out  1  controller accepts pixel this cycle.
- out_stall  in  1  downstream backpressure; blocks new pixel acceptance.
- shifting  out  1  shift enable to the shift register bank.
- sr_data  out  `WID_FIFO  data to shift register input (inp_sr).
- win_valid  out  1  window complete, one-cycle pulse.
- win_row  out  DIM_W  top-left row of reported window.
- win_col  out  DIM_W  top-left column of reported window.
- busy  out  1  high in RUN and FLUSH.
- done  out  1  one-cycle frame-complete pulse.
- cfg_err  out  1  one-cycle pulse when start carries an illegal size.

Behaviour:
- States: IDLE, RUN, FLUSH, DONE. All transitions are on the clk edge.
- IDLE:
  - start=1 with img_width>=KSIZE and img_height>=KSIZE: latch dims, clear col/row, go to RUN.
  - start=1 with img_width<KSIZE or img_height<KSIZE: pulse cfg_err next cycle, stay in IDLE, no windows.
- RUN:
  - pix_ready = !out_stall (combinational). Outside RUN, pix_ready=0.
  - fire = pix_valid & pix_ready.
  - shifting = fire (combinational), so the shift registers capture pix_data on the same edge.
  - sr_data = pix_data passthrough.
  - On fire: col increments. When col==width-1 it wraps to 0 and row increments.
  - When firing the pixel at col=width-1, row=height-1: go to FLUSH.
- win_valid timing:
  - win_valid is registered. It is 1 in the cycle after a fire whose pixel had col>=KSIZE-1 and row>=KSIZE-1.
  - In that cycle, win_row = row-(KSIZE-1) and win_col = col-(KSIZE-1) of the fired pixel.
  - win_row and win_col hold their values when win_valid=0.
- out_stall: gates only new fires. A win_valid already scheduled is still emitted while out_stall=1; downstream sizes its slack for one pulse.
- FLUSH: one cycle; carries the final win_valid; busy=1; then go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- abort in RUN: next state is IDLE. No done pulse. Pending win_valid is suppressed. Counters are cleared.
- start while not in IDLE: ignored. abort outside RUN: ignored. If abort and the last-pixel fire occur in the same cycle, abort wins.
- Reset (any state, including mid-frame) forces:
  - state=IDLE, col=row=0, latched dims=0.
  - win_valid=0, win_row=0, win_col=0, done=0, cfg_err=0, busy=0.
  - pix_ready and shifting are 0 via IDLE. The shift register bank is reset by the same rst.
- Arithmetic: counters are unsigned DIM_W-bit. Comparisons use latched dims. No overflow is possible because dims are at most 2^DIM_W-1.
- Window count per frame: (width-KSIZE+1)*(height-KSIZE+1).

Optional Feature:
- Macro: CONV_WINDOW_STRIDE2_EN.
- Defined: win_valid is asserted only when both win_row and win_col are even (stride 2). Window count is ceil((width-KSIZE+1)/2)*ceil((height-KSIZE+1)/2). Shifting and counters are unchanged.
- Undefined: stride 1; every complete window is flagged.

Test Plan:
- Frame, no stall: rst, start with width=5, height=4, KSIZE=3, pix_valid held high.
  - 20 shifting cycles.
  - 6 win_valid pulses at (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - First pulse in the cycle after the 13th fire.
  - done pulses 2 cycles after the last fire; busy low afterwards.
- Backpressure: same frame with out_stall high for cycles 8-11 of RUN.
  - pix_ready=0 and shifting=0 for those cycles.
  - Total fires still 20; win_valid count still 6 with unchanged coordinates.
- Illegal config: start with width=2, height=8.
  - cfg_err pulses once; busy stays 0; no shifting, no win_valid, no done.
- Abort: start 5x4, abort after the 10th fire.
  - Next cycle state is IDLE with pix_ready=0; no done, no further win_valid.
  - A new start then runs a full frame with 6 windows.
- Mid-frame reset: rst asserted after the 14th fire.
  - Next cycle win_valid=0, busy=0, win_row=win_col=0.
  - start ignored during rst; a subsequent frame behaves as in the first scenario.
- CONV_WINDOW_STRIDE2_EN defined, 5x4 frame: exactly 2 win_valid pulses at (0,0) and (0,2).
